// File: rtl/scu_int_ctrl_pkg.sv
// Shared types, register masks and helpers for the SCU interrupt controller.
// Register masks are functions because the package cannot see the block parameters.
package scu_int_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_HOLD
  } int_state_e;

  typedef struct packed {
    logic [3:0] src;
    logic       ext;
    logic [3:0] lvl;
    logic [7:0] vec;
  } winner_t;

  localparam logic [1:0] SEL_IMS   = 2'd0;
  localparam logic [1:0] SEL_IST   = 2'd1;
  localparam logic [1:0] SEL_AIACK = 2'd2;
  localparam logic [1:0] SEL_LVL   = 2'd3;

  localparam logic [31:0] AIACK_WMASK = 32'h0000_0001;
  localparam logic [31:0] AIACK_RMASK = 32'h0000_0001;
  localparam logic [31:0] AIACK_INIT  = '0;
  localparam logic [31:0] IST_INIT    = '0;

  // Internal sources on bits [num_int-1:0], shared external mask on bit 15.
  function automatic logic [31:0] ims_wmask(input int unsigned num_int);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < num_int; i++) m[i] = 1'b1;
    m[15] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ims_rmask(input int unsigned num_int);
    return ims_wmask(num_int);
  endfunction

  function automatic logic [31:0] ims_init(input int unsigned num_int);
    return ims_wmask(num_int);
  endfunction

  function automatic logic [31:0] ist_rmask(input int unsigned num_int,
                                            input int unsigned num_ext);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < num_int; i++) m[i] = 1'b1;
    for (int unsigned j = 0; j < num_ext; j++) m[16+j] = 1'b1;
    return m;
  endfunction

  // {ext, src} is exactly the IST bit position of a source.
  function automatic logic [31:0] src_bit(input logic ext, input logic [3:0] src);
    logic [31:0] b;
    b = '0;
    b[{ext, src}] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/scu_int_ctrl_if.sv
// Register-decoder, event-source and SH-2 signals of the SCU interrupt controller.
interface scu_int_ctrl_if #(
  parameter int unsigned NUM_INT = 14,
  parameter int unsigned NUM_EXT = 16
);
  logic [1:0]         REG_SEL;
  logic               REG_WR;
  logic [31:0]        REG_DI;
  logic [31:0]        REG_DO;
  logic [NUM_INT-1:0] INT_IN;
  logic [NUM_EXT-1:0] EXT_IN;
  logic [3:0]         IRL;
  logic [7:0]         VEC;
  logic               IACK;

  modport master (
    output REG_SEL, REG_WR, REG_DI, INT_IN, EXT_IN, IACK,
    input  REG_DO, IRL, VEC
  );

  modport slave (
    input  REG_SEL, REG_WR, REG_DI, INT_IN, EXT_IN, IACK,
    output REG_DO, IRL, VEC
  );
endinterface

// File: rtl/scu_int_ctrl_prio.sv
// Combinational winner selection: highest level, internal before external, low index first.
module scu_int_prio
  import scu_int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INT      = 14,
  parameter int unsigned NUM_EXT      = 16,
  parameter logic [7:0]  VEC_INT_BASE = 8'h40,
  parameter logic [7:0]  VEC_EXT_BASE = 8'h50
) (
  input  logic [NUM_INT-1:0]   cand_int,
  input  logic [NUM_EXT-1:0]   cand_ext,
  input  logic [NUM_INT*4-1:0] lvl_int,
  input  logic [NUM_EXT*4-1:0] lvl_ext,
  output logic                 valid,
  output winner_t              win
);

  // Strict '>' keeps the earlier (internal, lower-index) source on ties.
  always_comb begin
    valid = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_INT; i++) begin
      if (cand_int[i] && (!valid || lvl_int[4*i +: 4] > win.lvl)) begin
        valid   = 1'b1;
        win.src = 4'(i);
        win.ext = 1'b0;
        win.lvl = lvl_int[4*i +: 4];
        win.vec = VEC_INT_BASE + 8'(i);
      end
    end
    for (int unsigned j = 0; j < NUM_EXT; j++) begin
      if (cand_ext[j] && (!valid || lvl_ext[4*j +: 4] > win.lvl)) begin
        valid   = 1'b1;
        win.src = 4'(j);
        win.ext = 1'b1;
        win.lvl = lvl_ext[4*j +: 4];
        win.vec = VEC_EXT_BASE + 8'(j);
      end
    end
  end

endmodule

// File: rtl/scu_int_ctrl.sv
// SCU interrupt controller: IMS/IST/AIACK registers, priority select, SH-2 IRL handshake.
// Optional SCU_INT_LEVEL_PROG_EN makes levels of sources 0..7 programmable via REG_SEL=3.
module scu_int_ctrl
  import scu_int_ctrl_pkg::*;
#(
  parameter int unsigned          NUM_INT      = 14,
  parameter int unsigned          NUM_EXT      = 16,
  parameter logic [NUM_INT*4-1:0] INT_LVL      = 56'h3556_6889_ABCD_EF,
  parameter logic [NUM_EXT*4-1:0] EXT_LVL      = 64'h4444_4444_4444_7777,
  parameter logic [7:0]           VEC_INT_BASE = 8'h40,
  parameter logic [7:0]           VEC_EXT_BASE = 8'h50
) (
  input logic            CLK,
  input logic            RST,
  input logic            CE,
  scu_int_ctrl_if.slave  bus
);

  localparam logic [31:0] IMS_WMASK = ims_wmask(NUM_INT);
  localparam logic [31:0] IMS_RMASK = ims_rmask(NUM_INT);
  localparam logic [31:0] IMS_INIT  = ims_init(NUM_INT);
  localparam logic [31:0] IST_RMASK = ist_rmask(NUM_INT, NUM_EXT);

  logic [31:0]          ims, ist, ist_n, ev, cand, lvl_rd;
  logic                 aiack, ack, ext_gate, latched_live, win_valid;
  logic [NUM_INT*4-1:0] lvl_tbl;
  winner_t              win, cur, cur_n;
  int_state_e           state, state_n;

  wire wr_ims   = bus.REG_WR && (bus.REG_SEL == SEL_IMS);
  wire wr_ist   = bus.REG_WR && (bus.REG_SEL == SEL_IST);
  wire wr_aiack = bus.REG_WR && (bus.REG_SEL == SEL_AIACK);

`ifdef SCU_INT_LEVEL_PROG_EN
  function automatic logic [31:0] lvl_init();
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (i < NUM_INT) r[4*i +: 4] = INT_LVL[4*i +: 4];
    return r;
  endfunction

  logic [31:0] lvl_reg;

  always_ff @(posedge CLK) begin
    if (RST)
      lvl_reg <= lvl_init();
    else if (CE && bus.REG_WR && (bus.REG_SEL == SEL_LVL))
      lvl_reg <= bus.REG_DI;
  end

  always_comb begin
    lvl_tbl = INT_LVL;
    for (int unsigned i = 0; i < 8; i++)
      if (i < NUM_INT) lvl_tbl[4*i +: 4] = lvl_reg[4*i +: 4];
  end

  assign lvl_rd = lvl_reg;
`else
  assign lvl_tbl = INT_LVL;
  assign lvl_rd  = '0;
`endif

  always_comb begin
    cand = '0;
    cand[NUM_INT-1:0]   = ist[NUM_INT-1:0] & ~ims[NUM_INT-1:0];
    cand[16 +: NUM_EXT] = ist[16 +: NUM_EXT] & {NUM_EXT{~ims[15]}};
  end

  assign latched_live = cand[{cur.ext, cur.src}];

  scu_int_prio #(
    .NUM_INT      (NUM_INT),
    .NUM_EXT      (NUM_EXT),
    .VEC_INT_BASE (VEC_INT_BASE),
    .VEC_EXT_BASE (VEC_EXT_BASE)
  ) u_prio (
    .cand_int (cand[NUM_INT-1:0]),
    .cand_ext (cand[16 +: NUM_EXT]),
    .lvl_int  (lvl_tbl),
    .lvl_ext  (EXT_LVL),
    .valid    (win_valid),
    .win      (win)
  );

  always_comb begin
    state_n = state;
    cur_n   = cur;
    ack     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_valid) begin
          cur_n   = win;
          state_n = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (bus.IACK) begin
          ack     = 1'b1;
          state_n = ST_HOLD;
        end else if (!latched_live) begin
          state_n = ST_HOLD;
        end else if (win_valid && (win.lvl > cur.lvl)) begin
          cur_n = win;
        end
      end
      ST_HOLD:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // An acknowledge that consumes AIACK also blocks external latching in that same cycle.
  assign ext_gate = aiack && !ims[15] && !(ack && cur.ext);

  always_comb begin
    ev = '0;
    ev[NUM_INT-1:0] = bus.INT_IN;
    if (ext_gate) ev[16 +: NUM_EXT] = bus.EXT_IN;
    ist_n = ist;
    if (wr_ist) ist_n = ist_n & bus.REG_DI;
    if (ack)    ist_n = ist_n & ~src_bit(cur.ext, cur.src);
    // New events are ORed last so they survive a same-cycle clear.
    ist_n = (ist_n | ev) & IST_RMASK;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else if (CE) begin
      state <= state_n;
      cur   <= cur_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ims   <= IMS_INIT;
      ist   <= IST_INIT;
      aiack <= AIACK_INIT[0];
    end else if (CE) begin
      ist <= ist_n;
      if (wr_ims) ims <= bus.REG_DI & IMS_WMASK;
      if (wr_aiack)
        aiack <= bus.REG_DI[0];
      else if (ack && cur.ext)
        aiack <= 1'b0;
    end
  end

  assign bus.IRL = (state == ST_ASSERT) ? cur.lvl : 4'h0;
  assign bus.VEC = (state == ST_ASSERT) ? cur.vec : 8'h00;

  always_comb begin
    bus.REG_DO = '0;
    unique case (bus.REG_SEL)
      SEL_IMS:   bus.REG_DO = ims & IMS_RMASK;
      SEL_IST:   bus.REG_DO = ist & IST_RMASK;
      SEL_AIACK: bus.REG_DO = {31'b0, aiack} & AIACK_RMASK;
      SEL_LVL:   bus.REG_DO = lvl_rd;
      default:   bus.REG_DO = '0;
    endcase
  end

endmodule

// File: tb/tb_scu_int_ctrl.sv
// Directed self-checking bench for scu_int_ctrl (default parameters, default build).
module tb_scu_int_ctrl;

  logic CLK = 1'b0;
  logic RST;
  logic CE;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] d;

  scu_int_ctrl_if #(.NUM_INT(14), .NUM_EXT(16)) bus ();

  scu_int_ctrl #(.NUM_INT(14), .NUM_EXT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .CE  (CE),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    bus.REG_SEL = sel;
    bus.REG_DI  = data;
    bus.REG_WR  = 1'b1;
    tick();
    bus.REG_WR  = 1'b0;
    bus.REG_DI  = '0;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] data);
    bus.REG_SEL = sel;
    #1;
    data = bus.REG_DO;
  endtask

  task automatic pulse_int(input logic [13:0] m);
    bus.INT_IN = m;
    tick();
    bus.INT_IN = '0;
  endtask

  task automatic do_iack();
    bus.IACK = 1'b1;
    tick();
    bus.IACK = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    rd(2'd0, d); n_checks++;
    if (d !== 32'h0000BFFF) begin n_fail++; $display("FAIL reset_ims: got %h expected %h", d, 32'h0000BFFF); end
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ist: got %h expected %h", d, 32'h0); end
    rd(2'd2, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_aiack: got %h expected %h", d, 32'h0); end
    rd(2'd3, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_lvl_reg: got %h expected %h", d, 32'h0); end
    n_checks++;
    if (bus.IRL !== 4'h0 || bus.VEC !== 8'h00) begin n_fail++; $display("FAIL reset_irl_vec: got %h/%h expected 0/00", bus.IRL, bus.VEC); end
  endtask

  task automatic test_masked_event();
    pulse_int(14'h0001);
    rd(2'd1, d); n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL masked_ist: got %h expected %h", d, 32'h1); end
    tick(); tick(); n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL masked_irl: got %h expected 0", bus.IRL); end
  endtask

  task automatic test_basic_irq();
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL basic_ims_clear: got %h expected %h", d, 32'h0); end
    pulse_int(14'h0001);
    n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL basic_latency: got %h expected 0", bus.IRL); end
    tick(); n_checks++;
    if (bus.IRL !== 4'hF || bus.VEC !== 8'h40) begin n_fail++; $display("FAIL basic_irl_vec: got %h/%h expected F/40", bus.IRL, bus.VEC); end
    do_iack();
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL basic_ist_ack: got %h expected %h", d, 32'h0); end
    n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL basic_hold_irl: got %h expected 0", bus.IRL); end
    tick(); n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL basic_idle_irl: got %h expected 0", bus.IRL); end
  endtask

  task automatic test_preempt();
    pulse_int(14'h2000);
    tick(); n_checks++;
    if (bus.IRL !== 4'h3 || bus.VEC !== 8'h4D) begin n_fail++; $display("FAIL preempt_first: got %h/%h expected 3/4D", bus.IRL, bus.VEC); end
    pulse_int(14'h0004);
    n_checks++;
    if (bus.IRL !== 4'h3) begin n_fail++; $display("FAIL preempt_latency: got %h expected 3", bus.IRL); end
    tick(); n_checks++;
    if (bus.IRL !== 4'hD || bus.VEC !== 8'h42) begin n_fail++; $display("FAIL preempt_switch: got %h/%h expected D/42", bus.IRL, bus.VEC); end
    do_iack();
    n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL preempt_hold: got %h expected 0", bus.IRL); end
    tick(); tick(); n_checks++;
    if (bus.IRL !== 4'h3 || bus.VEC !== 8'h4D) begin n_fail++; $display("FAIL preempt_resume: got %h/%h expected 3/4D", bus.IRL, bus.VEC); end
    do_iack(); tick();
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL preempt_ist_empty: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_cancel();
    pulse_int(14'h0008);
    tick(); n_checks++;
    if (bus.IRL !== 4'hC || bus.VEC !== 8'h43) begin n_fail++; $display("FAIL cancel_assert: got %h/%h expected C/43", bus.IRL, bus.VEC); end
    wr(2'd1, ~32'h8);
    n_checks++;
    if (bus.IRL !== 4'hC) begin n_fail++; $display("FAIL cancel_pending: got %h expected C", bus.IRL); end
    tick(); n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL cancel_drop: got %h expected 0", bus.IRL); end
    tick(); tick();
  endtask

  task automatic test_tie();
    pulse_int(14'h0180);
    tick(); n_checks++;
    if (bus.IRL !== 4'h8 || bus.VEC !== 8'h47) begin n_fail++; $display("FAIL tie_low_index: got %h/%h expected 8/47", bus.IRL, bus.VEC); end
    do_iack(); tick(); tick(); n_checks++;
    if (bus.IRL !== 4'h8 || bus.VEC !== 8'h48) begin n_fail++; $display("FAIL tie_second: got %h/%h expected 8/48", bus.IRL, bus.VEC); end
    do_iack(); tick();
  endtask

  task automatic test_external();
    wr(2'd0, 32'h0000_3FFF);
    wr(2'd2, 32'h1);
    bus.EXT_IN = 16'h0001;
    tick();
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL ext_ist: got %h expected %h", d, 32'h0001_0000); end
    tick(); n_checks++;
    if (bus.IRL !== 4'h7 || bus.VEC !== 8'h50) begin n_fail++; $display("FAIL ext_irl_vec: got %h/%h expected 7/50", bus.IRL, bus.VEC); end
    bus.EXT_IN = '0;
    do_iack();
    rd(2'd2, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ext_aiack_clear: got %h expected %h", d, 32'h0); end
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ext_ist_ack: got %h expected %h", d, 32'h0); end
    bus.EXT_IN = 16'h0002;
    tick(); tick(); tick();
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0 || bus.IRL !== 4'h0) begin n_fail++; $display("FAIL ext_ignored: got ist %h irl %h expected 0/0", d, bus.IRL); end
    wr(2'd2, 32'h1);
    tick();
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0002_0000) begin n_fail++; $display("FAIL ext_rearm_ist: got %h expected %h", d, 32'h0002_0000); end
    tick(); n_checks++;
    if (bus.IRL !== 4'h7 || bus.VEC !== 8'h51) begin n_fail++; $display("FAIL ext_rearm_irl: got %h/%h expected 7/51", bus.IRL, bus.VEC); end
    bus.EXT_IN = '0;
    do_iack(); tick();
  endtask

  task automatic test_event_wins();
    wr(2'd0, 32'h0000_BFFF);
    bus.INT_IN  = 14'h0020;
    bus.REG_SEL = 2'd1;
    bus.REG_DI  = ~32'h20;
    bus.REG_WR  = 1'b1;
    tick();
    bus.INT_IN = '0;
    bus.REG_WR = 1'b0;
    rd(2'd1, d); n_checks++;
    if (d !== 32'h20) begin n_fail++; $display("FAIL event_wins: got %h expected %h", d, 32'h20); end
    wr(2'd1, 32'h0);
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ist_sw_clear: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_clock_enable();
    CE = 1'b0;
    wr(2'd0, 32'h0);
    pulse_int(14'h0001);
    CE = 1'b1;
    rd(2'd0, d); n_checks++;
    if (d !== 32'h0000BFFF) begin n_fail++; $display("FAIL ce_ims_hold: got %h expected %h", d, 32'h0000BFFF); end
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ce_ist_hold: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid();
    wr(2'd0, 32'h0);
    pulse_int(14'h0002);
    tick(); n_checks++;
    if (bus.IRL !== 4'hE || bus.VEC !== 8'h41) begin n_fail++; $display("FAIL rstmid_assert: got %h/%h expected E/41", bus.IRL, bus.VEC); end
    RST = 1'b1;
    tick(); n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL rstmid_irl: got %h expected 0", bus.IRL); end
    rd(2'd1, d); n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_ist: got %h expected %h", d, 32'h0); end
    rd(2'd0, d); n_checks++;
    if (d !== 32'h0000BFFF) begin n_fail++; $display("FAIL rstmid_ims: got %h expected %h", d, 32'h0000BFFF); end
    RST = 1'b0;
    tick(); tick(); n_checks++;
    if (bus.IRL !== 4'h0) begin n_fail++; $display("FAIL rstmid_after: got %h expected 0", bus.IRL); end
  endtask

  initial begin
    RST         = 1'b1;
    CE          = 1'b1;
    bus.REG_SEL = '0;
    bus.REG_WR  = 1'b0;
    bus.REG_DI  = '0;
    bus.INT_IN  = '0;
    bus.EXT_IN  = '0;
    bus.IACK    = 1'b0;
    test_reset();
    test_masked_event();
    test_basic_irq();
    test_preempt();
    test_cancel();
    test_tie();
    test_external();
    test_event_wins();
    test_clock_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
